// File: rtl/param_shift_add_mult.sv
// ---------------------------------------------------------------------------
// param_shift_add_mult
//
// Sequential shift-add multiplier. Operands are captured on a start
// handshake, one add-and-shift iteration runs per clock for WIDTH clocks,
// then one fix-up cycle applies the sign for two's-complement mode before
// the product register is written and a one-cycle done pulse is raised.
//
// Signed mode works on magnitudes: both operands are made non-negative at
// capture, multiplied unsigned, and the product is negated at the end when
// exactly one operand was negative.
//
// Ports:
//   i_CLK     in   1        clock, rising edge
//   i_RESET   in   1        asynchronous active-low reset
//   i_START   in   1        request a multiplication
//   i_A       in   WIDTH    multiplicand, captured on the accepting edge
//   i_B       in   WIDTH    multiplier, captured on the accepting edge
//   i_SIGNED  in   1        1 = two's-complement operands and product
//   o_BUSY    out  1        high while an operation is in flight
//   o_DONE    out  1        one-cycle pulse, o_P has just been written
//   o_P       out  2*WIDTH  product register, held until the next result
// ---------------------------------------------------------------------------
module param_shift_add_mult #(
    parameter int WIDTH = 4
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET,
    input  logic                 i_START,
    input  logic [WIDTH-1:0]     i_A,
    input  logic [WIDTH-1:0]     i_B,
    input  logic                 i_SIGNED,
    output logic                 o_BUSY,
    output logic                 o_DONE,
    output logic [2*WIDTH-1:0]   o_P
);

    localparam int             CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   q;
    logic [WIDTH:0]     acc;
    logic [CW-1:0]      count;
    logic               neg;

    // Magnitude of an operand; the most-negative value maps to 2^(WIDTH-1),
    // which still fits as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    logic [WIDTH-1:0]   cap_m;
    logic [WIDTH-1:0]   cap_q;
    logic               cap_neg;
    logic               accept;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        cap_m       = magnitude(i_A, i_SIGNED);
        cap_q       = magnitude(i_B, i_SIGNED);
        cap_neg     = i_SIGNED & (i_A[WIDTH-1] ^ i_B[WIDTH-1]);
        // The DONE cycle closes the operation; a start seen at its closing
        // edge begins the next one back-to-back.
        accept      = i_START && ((state == S_IDLE) || (state == S_DONE));
        addend      = q[0] ? m : '0;
        sum         = acc + {1'b0, addend};
        product     = {acc[WIDTH-1:0], q};
        product_fix = neg ? -product : product;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_CLK or negedge i_RESET) begin
        if (!i_RESET) begin
            // NOTE: the datapath registers are reset too, so no stale operand survives an abort.
            state  <= S_IDLE;
            m      <= '0;
            q      <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            o_P    <= '0;
            o_BUSY <= 1'b0;
            o_DONE <= 1'b0;
        end else if (accept) begin
            m      <= cap_m;
            q      <= cap_q;
            acc    <= '0;
            count  <= '0;
            neg    <= cap_neg;
            state  <= S_CALC;
            o_BUSY <= 1'b1;
            o_DONE <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_BUSY <= 1'b0;
                    o_DONE <= 1'b0;
                end
                S_CALC: begin
                    // {acc,q} <= {sum,q} >> 1: the sum LSB drops into the
                    // multiplier register as the consumed bit shifts out.
                    acc   <= {1'b0, sum[WIDTH:1]};
                    q     <= {sum[0], q[WIDTH-1:1]};
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    o_P    <= product_fix;
                    o_DONE <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    o_DONE <= 1'b0;
                    o_BUSY <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    o_DONE <= 1'b0;
                    o_BUSY <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
